seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg_display_ctrl_if.sv | 23 ++
 rtl/seg_display_ctrl_bin2seg.sv | 41 ++++
 rtl/seg_display_ctrl.sv | 115 +++++++++++
 tb/tb_seg_display_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the two-requester 7-segment display controller.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int CNT_W = 26;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Requester/display bundle: two req/val pairs in, grants, busy and digit outputs back.
interface seg_display_ctrl_if;
  logic       req_a;
  logic [3:0] val_a;
  logic       req_b;
  logic [3:0] val_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       busy;
  logic [4:0] bcd;
  logic [6:0] hex0;
  logic [6:0] hex1;

  modport master (
    output req_a, val_a, req_b, val_b,
    input  gnt_a, gnt_b, busy, bcd, hex0, hex1
  );

  modport slave (
    input  req_a, val_a, req_b, val_b,
    output gnt_a, gnt_b, busy, bcd, hex0, hex1
  );
endinterface

// File: rtl/seg_display_ctrl_bin2seg.sv
// Combinational 0..15 binary to {tens,units} BCD and two active-low digit patterns.
// A blank request overrides everything with dark segments and zero BCD.
module bin2seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bin,
  input  logic       i_blank,
  output logic [4:0] o_bcd,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex0
);

  logic [3:0] w_units;
  logic       w_tens;

  // Split into tens/units and look up the digit patterns.
  always_comb begin
    w_units = i_bin;
    w_tens  = 1'b0;
    o_bcd   = 5'b00000;
    o_hex1  = SEG_BLANK;
    o_hex0  = SEG_BLANK;
    if (i_blank) begin
      o_bcd  = 5'b00000;
      o_hex1 = SEG_BLANK;
      o_hex0 = SEG_BLANK;
    end else begin
      if (i_bin >= 4'd10) begin
        w_tens  = 1'b1;
        w_units = i_bin - 4'd10;
      end else begin
        w_tens  = 1'b0;
        w_units = i_bin;
      end
      o_bcd  = {w_tens, w_units};
      o_hex1 = w_tens ? SEG_1 : SEG_0;
      o_hex0 = seg_digit(w_units);
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Arbitrates two requesters onto one 2-digit display and holds each granted
// value for HOLD_CYCLES cycles; ties go to whoever was not granted last.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_display_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_gnt_a;
  logic              r_gnt_b;
  logic              r_last_b;
  logic [3:0]        r_disp;
  logic              r_blank;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_gnt_a_nxt;
  logic              w_gnt_b_nxt;
  logic              w_last_b_nxt;
  logic [3:0]        w_disp_nxt;
  logic              w_blank_nxt;
  logic              w_sel_b;
  logic [4:0]        w_bcd;
  logic [6:0]        w_hex1;
  logic [6:0]        w_hex0;

  // Next-state, arbitration and hold-counter logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gnt_a_nxt  = 1'b0;
    w_gnt_b_nxt  = 1'b0;
    w_last_b_nxt = r_last_b;
    w_disp_nxt   = r_disp;
    w_blank_nxt  = r_blank;
    w_sel_b      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_sel_b = ~r_last_b;
        end else begin
          w_sel_b = bus.req_b;
        end
        if (bus.req_a || bus.req_b) begin
          w_state_nxt  = ST_SHOW;
          w_cnt_nxt    = HOLD_LOAD;
          w_last_b_nxt = w_sel_b;
          w_disp_nxt   = w_sel_b ? bus.val_b : bus.val_a;
          w_blank_nxt  = 1'b0;
          w_gnt_a_nxt  = ~w_sel_b;
          w_gnt_b_nxt  = w_sel_b;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHOW: begin
        // Requests are deliberately not sampled here; they re-arbitrate in IDLE.
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, grant and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_last_b <= 1'b1;
      r_disp   <= 4'd0;
      r_blank  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt_a  <= w_gnt_a_nxt;
      r_gnt_b  <= w_gnt_b_nxt;
      r_last_b <= w_last_b_nxt;
      r_disp   <= w_disp_nxt;
      r_blank  <= w_blank_nxt;
    end
  end

  bin2seg u_bin2seg (
    .i_bin   (r_disp),
    .i_blank (r_blank),
    .o_bcd   (w_bcd),
    .o_hex1  (w_hex1),
    .o_hex0  (w_hex0)
  );

  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.busy  = (r_state == ST_SHOW);
  assign bus.bcd   = w_bcd;
  assign bus.hex1  = w_hex1;
  assign bus.hex0  = w_hex0;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomised and directed bench for seg_display_ctrl with HOLD_CYCLES=4,
// compared every cycle against a behavioural model of the display rules.
module tb_seg_display_ctrl;

  localparam int H = 4;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_checks;

  seg_display_ctrl_if u_if ();

  seg_display_ctrl #(.HOLD_CYCLES(H)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: remaining hold cycles, who was granted last, what is shown
  int m_hold;
  bit m_last_b;
  bit m_gnt_a;
  bit m_gnt_b;
  int m_v;
  bit m_blank;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [4:0] b;
    logic [6:0] h1;
    logic [6:0] h0;
    if (m_blank) begin
      b = 5'd0; h1 = 7'b1111111; h0 = 7'b1111111;
    end else begin
      b  = (m_v >= 10) ? 5'd16 + 5'(m_v - 10) : 5'(m_v);
      h1 = ref_seg(m_v / 10);
      h0 = ref_seg(m_v % 10);
    end
    return {m_gnt_a, m_gnt_b, (m_hold > 0), b, h1, h0};
  endfunction

  function automatic logic [21:0] act_vec();
    return {u_if.gnt_a, u_if.gnt_b, u_if.busy, u_if.bcd, u_if.hex1, u_if.hex0};
  endfunction

  task automatic model_reset();
    m_hold = 0; m_last_b = 1'b1; m_gnt_a = 1'b0; m_gnt_b = 1'b0;
    m_v = 0; m_blank = 1'b1;
  endtask

  task automatic model_edge();
    bit take_a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_gnt_a = 1'b0;
    m_gnt_b = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (u_if.req_a || u_if.req_b) begin
      // A wins when alone, or when both ask and B had the previous grant
      take_a = u_if.req_a && (!u_if.req_b || m_last_b);
      m_v     = take_a ? int'(u_if.val_a) : int'(u_if.val_b);
      m_blank = 1'b0;
      m_hold  = H;
      m_last_b = !take_a;
      m_gnt_a = take_a;
      m_gnt_b = !take_a;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit ra, input int va, input bit rb, input int vb);
    u_if.req_a = ra; u_if.val_a = 4'(va);
    u_if.req_b = rb; u_if.val_b = 4'(vb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    model_reset();
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_contention();
    int gcyc[$];
    bit gb[$];
    drive(1'b1, 2, 1'b1, 9);
    for (int i = 0; i < 22; i++) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL contention cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (u_if.gnt_a || u_if.gnt_b) begin
        gcyc.push_back(i);
        gb.push_back(u_if.gnt_b);
        n_checks++;
        if (u_if.hex0 !== (u_if.gnt_b ? 7'b0010000 : 7'b0100100)) begin
          n_err++;
          $display("FAIL contention_hex0 cyc%0d: got %b", i, u_if.hex0);
        end
      end
    end
    n_checks++;
    if (gcyc.size() < 4) begin
      n_err++;
      $display("FAIL contention_count: got %0d grants expected >=4", gcyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (gb[k] !== bit'(k % 2) || gcyc[k] !== 5 * k) begin
          n_err++;
          $display("FAIL contention_order k%0d: got b=%0d at %0d expected b=%0d at %0d",
                   k, gb[k], gcyc[k], k % 2, 5 * k);
        end
      end
    end
    drive(1'b0, 0, 1'b0, 0);
    for (int i = 0; i < H + 2; i++) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL contention_drain cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int busy_n;
    int gnt_n;
    busy_n = 0;
    gnt_n  = 0;
    drive(1'b1, 13, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b0, 0);
    n_checks++;
    if ({u_if.gnt_a, u_if.bcd, u_if.hex1, u_if.hex0} !== {1'b1, 5'b10011, 7'b1111001, 7'b0110000}) begin
      n_err++;
      $display("FAIL single_13: got gnt=%b bcd=%b hex1=%b hex0=%b", u_if.gnt_a, u_if.bcd, u_if.hex1, u_if.hex0);
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL single cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      busy_n += int'(u_if.busy);
      gnt_n  += int'(u_if.gnt_a);
      step();
    end
    n_checks++;
    if (busy_n !== H || gnt_n !== 1) begin
      n_err++;
      $display("FAIL single_len: got busy=%0d gnt=%0d expected busy=%0d gnt=1", busy_n, gnt_n, H);
    end
  endtask

  task automatic test_ignore_show();
    int gb_n;
    gb_n = 0;
    drive(1'b1, 5, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b1, 11);
    step();
    drive(1'b0, 0, 1'b0, 0);
    for (int i = 0; i < H + 2; i++) begin
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ignore cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      gb_n += int'(u_if.gnt_b);
      step();
    end
    n_checks++;
    if (gb_n !== 0 || u_if.hex0 !== 7'b0010010) begin
      n_err++;
      $display("FAIL ignore_b: got gnt_b count %0d hex0 %b expected 0 and 0010010", gb_n, u_if.hex0);
    end
  endtask

  task automatic test_reset_mid_show();
    drive(1'b1, 15, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b0, 0);
    step();
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b1, 7);
    model_reset();
    #1;
    n_checks++;
    if ({u_if.busy, u_if.bcd, u_if.hex1, u_if.hex0} !== {1'b0, 5'b00000, 7'b1111111, 7'b1111111}) begin
      n_err++;
      $display("FAIL midreset_now: got busy=%b bcd=%b hex1=%b hex0=%b", u_if.busy, u_if.bcd, u_if.hex1, u_if.hex0);
    end
    repeat (2) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL midreset_hold: got %h expected %h", act_vec(), exp_vec());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (u_if.gnt_b !== 1'b1 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL midreset_regrant: got %h expected %h", act_vec(), exp_vec());
    end
    drive(1'b0, 0, 1'b0, 0);
    repeat (H + 1) step();
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      drive(1'b1, v, 1'b0, 0);
      step();
      drive(1'b0, 0, 1'b0, 0);
      n_checks++;
      if (act_vec() !== exp_vec() || m_v !== v) begin
        n_err++;
        $display("FAIL sweep v%0d: got %h expected %h", v, act_vec(), exp_vec());
      end
      repeat (H) step();
    end
  endtask

  task automatic test_random();
    bit ra;
    bit rb;
    int va;
    int vb;
    ra = 1'b0; rb = 1'b0; va = 0; vb = 0;
    for (int i = 0; i < 300; i++) begin
      // Requests stay up until the model says they were granted
      if (!ra || m_gnt_a) begin
        ra = ($urandom_range(0, 2) == 0);
        va = $urandom_range(0, 15);
      end
      if (!rb || m_gnt_b) begin
        rb = ($urandom_range(0, 2) == 0);
        vb = $urandom_range(0, 15);
      end
      drive(ra, va, rb, vb);
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    test_reset();
    test_contention();
    test_single();
    test_ignore_show();
    test_reset_mid_show();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
